// File: rtl/i2c_target_regif_if.sv
// i2c_target_regif_if: pad and register-file bundle for i2c_target_regif
// Pads: scl_in/sda_in levels in, sda_oe pulls SDA low.
// Register file: reg_addr/reg_wdata/reg_we/reg_re out, reg_rdata in; addr_len_2 selects 16-bit addressing.
// busy marks START..STOP. slave = target side, master = environment side.
interface i2c_target_regif_if #(parameter int DW = 32);
  logic          scl_in;
  logic          sda_in;
  logic          sda_oe;
  logic          addr_len_2;
  logic [15:0]   reg_addr;
  logic [DW-1:0] reg_wdata;
  logic          reg_we;
  logic          reg_re;
  logic [DW-1:0] reg_rdata;
  logic          busy;
  modport slave (
    input  scl_in, sda_in, addr_len_2, reg_rdata,
    output sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );
  modport master (
    output scl_in, sda_in, addr_len_2, reg_rdata,
    input  sda_oe, reg_addr, reg_wdata, reg_we, reg_re, busy
  );
endinterface

// File: rtl/i2c_target_regif.sv
// i2c_target_regif: I2C target decoding device address, 8/16-bit register address and data words into a register-file port
// Ports: clk system clock (>= 8x SCL); rst async active-low reset; bus (slave modport of i2c_target_regif_if)
//   carrying scl_in, sda_in, sda_oe, addr_len_2, reg_addr, reg_wdata, reg_we, reg_re, reg_rdata, busy.
// Optional: define I2C_TGT_GLITCH_FILTER_EN for a 3-sample majority filter on synchronised scl/sda.
module i2c_target_regif #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2,
  parameter int         DATA_BYTES  = 4
) (
  input logic               clk,
  input logic               rst,
  i2c_target_regif_if.slave bus
);
  localparam int W  = 8 * DATA_BYTES;
  localparam int BW = $clog2(DATA_BYTES + 1);
  typedef enum logic [3:0] {
    S_IDLE, S_DEV_ADDR, S_DEV_ACK, S_RADDR, S_RADDR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
  } state_t;
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic w_scl, w_sda, r_scl_d, r_sda_d;
  logic w_rise, w_fall, w_start, w_stop, w_last, w_match;
  state_t r_state, w_state_n;
  logic [3:0] r_cnt, w_cnt_n;
  logic [7:0] r_shift, w_shift_n;
  logic [BW-1:0] r_bytes, w_bytes_n;
  logic r_aidx, w_aidx_n, r_rw, w_rw_n, r_sda_oe, w_oe_n;
  logic [15:0] r_addr, w_addr_n;
  logic [W-1:0] r_wdata, w_wdata_n, r_rword, w_rword_n;
  logic r_we, w_we_n, r_re, w_re_n, r_re_d, r_busy, w_busy_n;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
`ifdef I2C_TGT_GLITCH_FILTER_EN
  // Majority of the current and two previous samples: a 1-cycle pulse never wins.
  logic [1:0] r_scl_h, r_sda_h;
  logic w_s, w_d;
  assign w_s = r_scl_sync[SYNC_STAGES-1];
  assign w_d = r_sda_sync[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_scl_h <= '1;
      r_sda_h <= '1;
    end else begin
      r_scl_h <= {r_scl_h[0], w_s};
      r_sda_h <= {r_sda_h[0], w_d};
    end
  assign w_scl = (w_s & r_scl_h[0]) | (w_s & r_scl_h[1]) | (r_scl_h[0] & r_scl_h[1]);
  assign w_sda = (w_d & r_sda_h[0]) | (w_d & r_sda_h[1]) | (r_sda_h[0] & r_sda_h[1]);
`else
  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];
`endif
  assign w_rise  = w_scl & ~r_scl_d;
  assign w_fall  = ~w_scl & r_scl_d;
  assign w_start = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop  = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_last  = r_bytes == BW'(DATA_BYTES - 1);
  assign w_match = r_shift[7:1] == DEV_ADDR;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_bytes  <= '0;
      r_aidx   <= 1'b0;
      r_rw     <= 1'b0;
      r_sda_oe <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rword  <= '0;
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_re_d   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_cnt    <= w_cnt_n;
      r_shift  <= w_shift_n;
      r_bytes  <= w_bytes_n;
      r_aidx   <= w_aidx_n;
      r_rw     <= w_rw_n;
      r_sda_oe <= w_oe_n;
      r_addr   <= w_addr_n;
      r_wdata  <= w_wdata_n;
      r_rword  <= w_rword_n;
      r_we     <= w_we_n;
      r_re     <= w_re_n;
      r_re_d   <= r_re;
      r_busy   <= w_busy_n;
    end
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_shift_n = r_shift;
    w_bytes_n = r_bytes;
    w_aidx_n  = r_aidx;
    w_rw_n    = r_rw;
    w_oe_n    = r_sda_oe;
    w_addr_n  = r_we ? r_addr + 16'd1 : r_addr;
    w_wdata_n = r_wdata;
    w_rword_n = r_re_d ? bus.reg_rdata : r_rword;
    w_we_n    = 1'b0;
    w_re_n    = 1'b0;
    w_busy_n  = r_busy;
    if (w_start) begin
      w_state_n = S_DEV_ADDR;
      w_cnt_n   = '0;
      w_shift_n = '0;
      w_bytes_n = '0;
      w_aidx_n  = 1'b0;
      w_oe_n    = 1'b0;
      w_busy_n  = 1'b1;
    end else if (w_stop) begin
      w_state_n = S_IDLE;
      w_oe_n    = 1'b0;
      w_busy_n  = 1'b0;
    end else if (w_rise) begin
      case (r_state)
        S_DEV_ADDR, S_RADDR, S_WDATA: begin
          w_shift_n = {r_shift[6:0], w_sda};
          w_cnt_n   = r_cnt + 4'd1;
          if (r_state == S_WDATA) begin
            w_wdata_n = {r_wdata[W-2:0], w_sda};
            if (r_cnt == 4'd7) begin
              w_we_n    = w_last;
              w_bytes_n = w_last ? '0 : r_bytes + 1'b1;
            end
          end
        end
        S_RDATA: w_cnt_n = r_cnt + 4'd1;
        // Controller ACK/NACK; ACK on the last byte fetches the next word.
        S_RDATA_ACK: begin
          w_state_n = w_sda ? S_WAIT_STOP : S_RDATA_ACK;
          w_bytes_n = (w_sda || w_last) ? '0 : r_bytes + 1'b1;
          w_addr_n  = (!w_sda && w_last) ? r_addr + 16'd1 : r_addr;
          w_re_n    = !w_sda && w_last;
        end
        default: ;
      endcase
    end else if (w_fall) begin
      case (r_state)
        S_DEV_ADDR: if (r_cnt == 4'd8) begin
          w_state_n = w_match ? S_DEV_ACK : S_WAIT_STOP;
          w_oe_n    = w_match;
          w_rw_n    = r_shift[0];
          w_re_n    = w_match & r_shift[0];
        end
        S_RADDR: if (r_cnt == 4'd8) begin
          w_state_n = S_RADDR_ACK;
          w_oe_n    = 1'b1;
          w_aidx_n  = bus.addr_len_2 & ~r_aidx;
          w_addr_n  = (bus.addr_len_2 && !r_aidx) ? {r_shift, r_addr[7:0]}
                    : {bus.addr_len_2 ? r_addr[15:8] : 8'h00, r_shift};
        end
        S_WDATA: if (r_cnt == 4'd8) begin
          w_state_n = S_WDATA_ACK;
          w_oe_n    = 1'b1;
        end
        S_DEV_ACK: begin
          w_cnt_n   = '0;
          w_state_n = r_rw ? S_RDATA : S_RADDR;
          w_oe_n    = r_rw & ~r_rword[W-1];
        end
        S_RADDR_ACK: begin
          w_cnt_n   = '0;
          w_oe_n    = 1'b0;
          w_state_n = r_aidx ? S_RADDR : S_WDATA;
        end
        S_WDATA_ACK: begin
          w_cnt_n   = '0;
          w_oe_n    = 1'b0;
          w_state_n = S_WDATA;
        end
        // Word shifts left each fall so the next bit to drive always sits at the MSB.
        S_RDATA: begin
          w_rword_n = r_rword << 1;
          w_oe_n    = (r_cnt == 4'd8) ? 1'b0 : ~r_rword[W-2];
          w_state_n = (r_cnt == 4'd8) ? S_RDATA_ACK : S_RDATA;
        end
        S_RDATA_ACK: begin
          w_cnt_n   = '0;
          w_state_n = S_RDATA;
          w_oe_n    = ~r_rword[W-1];
        end
        default: ;
      endcase
    end
  end
  assign bus.sda_oe    = r_sda_oe;
  assign bus.reg_addr  = r_addr;
  assign bus.reg_wdata = r_wdata;
  assign bus.reg_we    = r_we;
  assign bus.reg_re    = r_re;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_i2c_target_regif.sv
// tb_i2c_target_regif: randomized self-checking bench for i2c_target_regif against a transaction-level model
`timescale 1ns/1ps
module tb_i2c_target_regif;
  localparam int Q = 5;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic m_scl = 1'b1;
  logic m_low = 1'b0;
  int errors = 0;
  int checks = 0;
  int busy_hits = 0;
  logic [31:0] salt;
  logic [47:0] we_q[$];
  logic [15:0] re_q[$];
  i2c_target_regif_if #(.DW(32)) bus ();
  i2c_target_regif dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.scl_in = m_scl;
  assign bus.sda_in = ~(m_low | bus.sda_oe);
  function automatic logic [31:0] rmodel(input logic [15:0] a);
    return {a, ~a} ^ salt;
  endfunction
  always @(posedge clk) if (bus.reg_re === 1'b1) bus.reg_rdata <= rmodel(bus.reg_addr);
  always @(negedge clk) begin
    if (bus.reg_we === 1'b1) we_q.push_back({bus.reg_addr, bus.reg_wdata});
    if (bus.reg_re === 1'b1) re_q.push_back(bus.reg_addr);
    if (bus.busy === 1'b1) busy_hits++;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wq();
    repeat (Q) @(posedge clk);
    #1;
  endtask
  task automatic i2c_start();
    m_low = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_low = 1'b1; wq();
    m_scl = 1'b0; wq();
  endtask
  task automatic i2c_stop();
    m_low = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_low = 1'b0; wq(); wq();
  endtask
  task automatic wbit(input logic b);
    m_low = ~b; wq();
    m_scl = 1'b1; wq(); wq();
    m_scl = 1'b0; wq();
  endtask
  task automatic rbit(output logic b);
    m_low = 1'b0; wq();
    m_scl = 1'b1; wq();
    b = bus.sda_in; wq();
    m_scl = 1'b0; wq();
  endtask
  task automatic wbyte(input logic [7:0] d, output int ack);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    rbit(a);
    ack = (a == 1'b0) ? 1 : 0;
  endtask
  task automatic rbyte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rbit(b);
      d[i] = b;
    end
    wbit(~ack);
  endtask
  // Write transaction: every complete word lands at base+k (16-bit wrap); trailing partial bytes never strobe.
  task automatic do_write(input logic a16, input logic [15:0] addr, input logic [31:0] words[$], input int extra);
    int ack, nack, wb;
    logic [15:0] base;
    logic [47:0] exp_q[$];
    wb = we_q.size();
    nack = 0;
    bus.addr_len_2 = a16;
    base = a16 ? addr : {8'h00, addr[7:0]};
    i2c_start();
    wbyte({7'h50, 1'b0}, ack); nack += ack;
    if (a16) begin wbyte(addr[15:8], ack); nack += ack; end
    wbyte(addr[7:0], ack); nack += ack;
    foreach (words[k]) begin
      exp_q.push_back({base + 16'(k), words[k]});
      for (int j = 3; j >= 0; j--) begin wbyte(words[k][8*j +: 8], ack); nack += ack; end
    end
    for (int j = 0; j < extra; j++) begin wbyte(8'($urandom), ack); nack += ack; end
    chk("w_busy_mid", bus.busy, 1'b1);
    i2c_stop();
    chk("w_acks", nack, (a16 ? 3 : 2) + 4 * words.size() + extra);
    chk("w_we_count", we_q.size() - wb, exp_q.size());
    foreach (exp_q[i]) if (wb + i < we_q.size()) chk("w_we_entry", we_q[wb + i], exp_q[i]);
    chk("w_busy_end", bus.busy, 1'b0);
  endtask
  // Read transaction: word k comes from register base+k, controller NACKs the final byte.
  task automatic do_read(input logic a16, input logic [15:0] addr, input int n);
    int ack, nack, rb, wb;
    logic [15:0] base;
    logic [31:0] exp;
    logic [7:0] d;
    rb = re_q.size();
    wb = we_q.size();
    nack = 0;
    bus.addr_len_2 = a16;
    base = a16 ? addr : {8'h00, addr[7:0]};
    i2c_start();
    wbyte({7'h50, 1'b0}, ack); nack += ack;
    if (a16) begin wbyte(addr[15:8], ack); nack += ack; end
    wbyte(addr[7:0], ack); nack += ack;
    i2c_start();
    wbyte({7'h50, 1'b1}, ack); nack += ack;
    for (int k = 0; k < n; k++) begin
      exp = rmodel(base + 16'(k));
      for (int j = 3; j >= 0; j--) begin
        rbyte(d, !(k == n - 1 && j == 0));
        chk("r_byte", d, exp[8*j +: 8]);
      end
    end
    chk("r_sda_released", bus.sda_oe, 1'b0);
    i2c_stop();
    chk("r_acks", nack, a16 ? 4 : 3);
    chk("r_re_count", re_q.size() - rb, n);
    for (int k = 0; k < n; k++) if (rb + k < re_q.size()) chk("r_re_addr", re_q[rb + k], base + 16'(k));
    chk("r_no_we", we_q.size() - wb, 0);
    chk("r_busy_end", bus.busy, 1'b0);
  endtask
  initial begin
    logic [31:0] ws[$];
    int ack, wb, rb, h0;
    salt = $urandom;
    bus.addr_len_2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_sda_oe", bus.sda_oe, 1'b0);
    chk("rst_we", bus.reg_we, 1'b0);
    chk("rst_re", bus.reg_re, 1'b0);
    chk("rst_addr", bus.reg_addr, 16'h0000);
    chk("rst_wdata", bus.reg_wdata, 32'h0);
    chk("rst_busy", bus.busy, 1'b0);
    rst = 1'b1;
    wq();
    ws = '{32'hDEADBEEF};
    do_write(1'b1, 16'h1234, ws, 0);
    do_read(1'b0, 16'h0005, 2);
    wb = we_q.size();
    rb = re_q.size();
    bus.addr_len_2 = 1'b0;
    i2c_start();
    wbyte({7'h51, 1'b0}, ack);
    chk("nm_dev_ack", ack, 0);
    wbyte(8'h3C, ack);
    chk("nm_byte_ack", ack, 0);
    chk("nm_busy_mid", bus.busy, 1'b1);
    i2c_stop();
    chk("nm_busy_end", bus.busy, 1'b0);
    chk("nm_no_we", we_q.size() - wb, 0);
    chk("nm_no_re", re_q.size() - rb, 0);
    ws = '{$urandom, $urandom};
    do_write(1'b1, 16'hFFFF, ws, 0);
    ws = '{};
    do_write(1'b1, 16'(($urandom)), ws, 2);
    for (int it = 0; it < 3; it++) begin
      ws = '{};
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) ws.push_back($urandom);
      do_write(1'($urandom), 16'($urandom), ws, int'($urandom_range(0, 3)));
      do_read(1'($urandom), 16'($urandom), int'($urandom_range(1, 2)));
    end
    i2c_start();
    for (int i = 7; i >= 1; i--) wbit(1'(7'h50 >> (i - 1)));
    wbit(1'b0);
    chk("ack_driven", bus.sda_oe, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_async_sda", bus.sda_oe, 1'b0);
    chk("rst_async_busy", bus.busy, 1'b0);
    wq();
    rst = 1'b1;
    wq();
    ws = '{$urandom};
    do_write(1'b0, 16'($urandom), ws, 0);
    m_scl = 1'b1;
    m_low = 1'b0;
    wq();
    h0 = busy_hits;
    @(posedge clk);
    #1 m_low = 1'b1;
    @(posedge clk);
    #1 m_low = 1'b0;
    wq(); wq();
`ifdef I2C_TGT_GLITCH_FILTER_EN
    chk("glitch_start", busy_hits - h0, 0);
`else
    chk("glitch_start", (busy_hits - h0) > 0, 1'b1);
`endif
    chk("glitch_busy_end", bus.busy, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
